pf_vf_tx_arb: RTL and testbench



---
 rtl/pf_vf_tx_arb_pkg.sv | 44 ++++
 rtl/pf_vf_tx_skid.sv | 88 ++++++++
 rtl/pf_vf_tx_arb.sv | 160 ++++++++++++++++
 tb/tb_pf_vf_tx_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_vf_tx_arb_pkg.sv
// Shared types and helpers for the PF/VF TX merge arbiter.
package pf_vf_tx_arb_pkg;

   localparam int unsigned META_PF_W  = 3;
   localparam int unsigned META_VF_W  = 11;
   localparam int unsigned MAX_PORT   = 16;
   localparam int unsigned MAX_PORT_W = 4;
   localparam int unsigned PICK_W     = MAX_PORT_W + 1;

   // Per-beat routing stamp carried alongside the data through the skid buffer.
   typedef struct packed {
      logic [META_PF_W-1:0]  pf;
      logic [META_VF_W-1:0]  vf;
      logic                  vf_active;
      logic [MAX_PORT_W-1:0] port;
   } t_tx_meta;

   typedef enum logic [0:0] {
      StIdle,
      StLocked
   } t_arb_state;

   // Returns {found, index}: first set bit of valid_vec at or above rr_ptr,
   // wrapping modulo num_port.
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_PORT-1:0]   valid_vec,
                                                 input logic [MAX_PORT_W-1:0] rr_ptr,
                                                 input int unsigned           num_port);
      logic [PICK_W-1:0] res;
      logic [PICK_W-1:0] sum;
      res = '0;
      for (int unsigned i = 0; i < MAX_PORT; i++) begin
         // rr_ptr and i are both below num_port, so one subtraction wraps.
         sum = {1'b0, rr_ptr} + PICK_W'(i);
         if (sum >= PICK_W'(num_port)) begin
            sum = sum - PICK_W'(num_port);
         end
         if ((i < num_port) && !res[MAX_PORT_W] && valid_vec[sum[MAX_PORT_W-1:0]]) begin
            res = {1'b1, sum[MAX_PORT_W-1:0]};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pf_vf_tx_skid.sv
// Two-entry AXI-S skid buffer carrying {tdata, tlast, t_tx_meta}.
// Outputs are registered; in_ready_o depends only on occupancy.
module pf_vf_tx_skid
   import pf_vf_tx_arb_pkg::*;
#(
   parameter int unsigned DATA_W = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_tdata_i,
   input  logic              in_tlast_i,
   input  t_tx_meta          in_meta_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_tdata_o,
   output logic              out_tlast_o,
   output t_tx_meta          out_meta_o
);

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic              tlast;
      t_tx_meta          meta;
   } t_entry;

   t_entry     head_q, head_d, tail_q, tail_d, in_entry;
   logic [1:0] cnt_q, cnt_d;
   logic       push, pop;

   // Occupancy bookkeeping; head always drives the outputs.
   always_comb begin
      in_entry = '{tdata: in_tdata_i, tlast: in_tlast_i, meta: in_meta_i};
      push     = in_valid_i && (cnt_q != 2'd2);
      pop      = (cnt_q != 2'd0) && out_ready_i;
      head_d   = head_q;
      tail_d   = tail_q;
      cnt_d    = cnt_q;
      case (cnt_q)
         2'd0: begin
            if (push) begin
               head_d = in_entry;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_entry;
            end else if (push) begin
               tail_d = in_entry;
               cnt_d  = 2'd2;
            end else if (pop) begin
               cnt_d  = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
      endcase
   end

   // Entry and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   // Registered-output view of the head entry.
   always_comb begin
      in_ready_o  = (cnt_q != 2'd2);
      out_valid_o = (cnt_q != 2'd0);
      out_tdata_o = head_q.tdata;
      out_tlast_o = head_q.tlast;
      out_meta_o  = head_q.meta;
   end

endmodule

// File: rtl/pf_vf_tx_arb.sv
// Merges NUM_PORT per-function AXI-S TX streams into one host stream with
// packet-atomic round-robin arbitration and PF/VF stamping.
// Optional PF_VF_TX_ARB_STATS_EN adds per-port packet counters and a sticky
// AXI-S valid-drop error flag.
module pf_vf_tx_arb
   import pf_vf_tx_arb_pkg::*;
#(
   parameter int unsigned NUM_PORT = 4,
   parameter int unsigned DATA_W   = 512,
   parameter int unsigned PF_W     = META_PF_W,
   parameter int unsigned VF_W     = META_VF_W,
   parameter int unsigned PORT_W   = $clog2(NUM_PORT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_PORT-1:0]        s_tvalid,
   output logic [NUM_PORT-1:0]        s_tready,
   input  logic [NUM_PORT*DATA_W-1:0] s_tdata,
   input  logic [NUM_PORT-1:0]        s_tlast,
   input  logic [NUM_PORT*PF_W-1:0]   cfg_pf,
   input  logic [NUM_PORT*VF_W-1:0]   cfg_vf,
   input  logic [NUM_PORT-1:0]        cfg_vf_active,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [DATA_W-1:0]          m_tdata,
   output logic                       m_tlast,
   output logic [PF_W-1:0]            m_pf,
   output logic [VF_W-1:0]            m_vf,
   output logic                       m_vf_active,
   output logic [PORT_W-1:0]          m_port
`ifdef PF_VF_TX_ARB_STATS_EN
   ,
   output logic [NUM_PORT*32-1:0]     stat_pkt_cnt,
   output logic                       stat_err
`endif
);

   t_arb_state        state_q, state_d;
   logic [PORT_W-1:0] grant_q, grant_d;
   logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PICK_W-1:0] pick;
   logic              skid_ready, in_valid, in_tlast, beat, beat_last;
   logic [DATA_W-1:0] in_tdata;
   t_tx_meta          in_meta, out_meta;
   logic              unused_port_hi;

   // Upstream mux: only the granted port sees ready, and only while LOCKED.
   always_comb begin
      pick              = rr_pick(MAX_PORT'(s_tvalid), MAX_PORT_W'(rr_ptr_q), NUM_PORT);
      in_valid          = (state_q == StLocked) && s_tvalid[grant_q];
      in_tdata          = s_tdata[grant_q*DATA_W +: DATA_W];
      in_tlast          = s_tlast[grant_q];
      in_meta.pf        = cfg_pf[grant_q*PF_W +: PF_W];
      in_meta.vf        = cfg_vf[grant_q*VF_W +: VF_W];
      in_meta.vf_active = cfg_vf_active[grant_q];
      in_meta.port      = MAX_PORT_W'(grant_q);
      s_tready          = '0;
      if (state_q == StLocked) begin
         s_tready[grant_q] = skid_ready;
      end
      beat      = in_valid && skid_ready;
      beat_last = beat && in_tlast;
   end

   // Grant FSM next state: pick in IDLE, release on the accepted tlast beat.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         StIdle: begin
            if (pick[MAX_PORT_W]) begin
               state_d = StLocked;
               grant_d = PORT_W'(pick[MAX_PORT_W-1:0]);
            end
         end
         StLocked: begin
            if (beat_last) begin
               state_d  = StIdle;
               rr_ptr_d = (grant_q == PORT_W'(NUM_PORT - 1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Grant FSM state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   pf_vf_tx_skid #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (skid_ready),
      .in_tdata_i  (in_tdata),
      .in_tlast_i  (in_tlast),
      .in_meta_i   (in_meta),
      .out_valid_o (m_tvalid),
      .out_ready_i (m_tready),
      .out_tdata_o (m_tdata),
      .out_tlast_o (m_tlast),
      .out_meta_o  (out_meta)
   );

   // Unpack the stamp carried with the head beat.
   always_comb begin
      m_pf        = out_meta.pf;
      m_vf        = out_meta.vf;
      m_vf_active = out_meta.vf_active;
      m_port      = PORT_W'(out_meta.port);
   end

   // Port field is sized for the largest legal NUM_PORT.
   assign unused_port_hi = ^out_meta.port;

`ifdef PF_VF_TX_ARB_STATS_EN
   logic [31:0] pkt_cnt_q [NUM_PORT];
   logic        stall_q, err_q;

   // Per-port packet counters and sticky valid-drop detector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NUM_PORT); i++) begin
            pkt_cnt_q[i] <= '0;
         end
         stall_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (beat_last) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
         end
         stall_q <= m_tvalid && !m_tready;
         if (stall_q && !m_tvalid) begin
            err_q <= 1'b1;
         end
      end
   end

   // Flatten counters onto the stats bus.
   always_comb begin
      for (int i = 0; i < int'(NUM_PORT); i++) begin
         stat_pkt_cnt[i*32 +: 32] = pkt_cnt_q[i];
      end
      stat_err = err_q;
   end
`endif

endmodule

// File: tb/tb_pf_vf_tx_arb.sv
// Self-checking bench for pf_vf_tx_arb: source models per port, an output
// scoreboard, a table of single-packet vectors and hand-written corner cases.
module tb_pf_vf_tx_arb;

   localparam int NP  = 4;
   localparam int DW  = 512;
   localparam int PFW = 3;
   localparam int VFW = 11;
   localparam int PW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP-1:0]     s_tvalid, s_tready, s_tlast, cfg_vf_active;
   logic [NP*DW-1:0]  s_tdata;
   logic [NP*PFW-1:0] cfg_pf;
   logic [NP*VFW-1:0] cfg_vf;
   logic              m_tvalid, m_tready, m_tlast, m_vf_active;
   logic [DW-1:0]     m_tdata;
   logic [PFW-1:0]    m_pf;
   logic [VFW-1:0]    m_vf;
   logic [PW-1:0]     m_port;
`ifdef PF_VF_TX_ARB_STATS_EN
   logic [NP*32-1:0]  stat_pkt_cnt;
   logic              stat_err;
`endif

   pf_vf_tx_arb #(
      .NUM_PORT (NP),
      .DATA_W   (DW),
      .PF_W     (PFW),
      .VF_W     (VFW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tdata       (s_tdata),
      .s_tlast       (s_tlast),
      .cfg_pf        (cfg_pf),
      .cfg_vf        (cfg_vf),
      .cfg_vf_active (cfg_vf_active),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .m_tdata       (m_tdata),
      .m_tlast       (m_tlast),
      .m_pf          (m_pf),
      .m_vf          (m_vf),
      .m_vf_active   (m_vf_active),
      .m_port        (m_port)
`ifdef PF_VF_TX_ARB_STATS_EN
      ,
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_err      (stat_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0]  tdata;
      logic           tlast;
      logic [PFW-1:0] pf;
      logic [VFW-1:0] vf;
      logic           vfa;
      logic [PW-1:0]  port;
   } beat_t;

   typedef struct {
      int port;
      int len;
      int exp_pf;
      int exp_vf;
      int exp_vfa;
      int exp_beats;
   } vec_t;

   int cfg_pf_t[NP]  = '{3, 6, 1, 7};
   int cfg_vf_t[NP]  = '{17, 100, 5, 2047};
   int cfg_vfa_t[NP] = '{0, 1, 1, 1};
   int rdy_pat[4]    = '{1, 0, 0, 1};

   int checks = 0;
   int failures = 0;

   // Source model state.
   int src_pkts[NP], src_len[NP], src_beat[NP], src_seq[NP];
   int src_stall_at[NP], src_stall_cnt[NP];

   // Scoreboard and observation state.
   beat_t sb[$];
   int    port_log[$];
   int    gaps[$];
   int    cyc, out_beats, intra_gap, stab_viol, multi_rdy, atom_viol;
   int    first_acc_cyc, first_out_cyc, last_tlast_cyc;
   bit    in_pkt, prev_stall, atom_watch;
   logic [PFW+VFW+PW:0]         first_meta;
   logic [DW+PFW+VFW+PW+2:0]    snap;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int p, input int s);
      logic [DW-1:0] d;
      d            = '0;
      d[31:0]      = s;
      d[39:32]     = p[7:0];
      d[DW-1 -: 32] = ~s;
      return d;
   endfunction

   task automatic clear_model();
      for (int p = 0; p < NP; p++) begin
         src_pkts[p] = 0; src_len[p] = 1; src_beat[p] = 0; src_seq[p] = p * 1000;
         src_stall_at[p] = -1; src_stall_cnt[p] = 0;
      end
      sb.delete(); port_log.delete(); gaps.delete();
      out_beats = 0; intra_gap = 0; stab_viol = 0; multi_rdy = 0; atom_viol = 0;
      first_acc_cyc = -1; first_out_cyc = -1; last_tlast_cyc = -1;
      in_pkt = 0; prev_stall = 0; atom_watch = 0; first_meta = '0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;
   endtask

   // One clock cycle: drive at the falling edge, then observe what the next
   // rising edge will sample.
   task automatic step(input logic rdy);
      beat_t e, got;
      @(negedge clk);
      cyc++;
      m_tready = rdy;
      for (int p = 0; p < NP; p++) begin
         s_tvalid[p] = 1'b0;
         s_tlast[p]  = 1'b0;
         if (src_pkts[p] > 0) begin
            if (src_beat[p] == src_stall_at[p] && src_stall_cnt[p] > 0) begin
               src_stall_cnt[p]--;
            end else begin
               s_tvalid[p] = 1'b1;
               s_tlast[p]  = (src_beat[p] == src_len[p] - 1);
               s_tdata[p*DW +: DW] = beat_data(p, src_seq[p]);
            end
         end
      end
      #1;
      if ($countones(s_tready) > 1) multi_rdy++;
      if (atom_watch && src_pkts[0] > 0 && s_tready[3]) atom_viol++;
      // Output side.
      if (prev_stall && snap !== {m_tvalid, m_tdata, m_tlast, m_pf, m_vf, m_vf_active, m_port})
         stab_viol++;
      if (first_out_cyc < 0 && m_tvalid) begin
         first_out_cyc = cyc;
         first_meta    = {m_pf, m_vf, m_vf_active, m_port};
      end
      if (m_tvalid && m_tready) begin
         got = '{tdata: m_tdata, tlast: m_tlast, pf: m_pf, vf: m_vf, vfa: m_vf_active,
                 port: m_port};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got port %0d data %0h expected no beat", m_port,
                     m_tdata[39:0]);
         end else begin
            e = sb.pop_front();
            if (got !== e) begin
               failures++;
               $display("FAIL sb_beat: got port %0d pf %0d vf %0d vfa %0b last %0b data %0h expected port %0d pf %0d vf %0d vfa %0b last %0b data %0h",
                        got.port, got.pf, got.vf, got.vfa, got.tlast, got.tdata[39:0],
                        e.port, e.pf, e.vf, e.vfa, e.tlast, e.tdata[39:0]);
            end
         end
         out_beats++;
         if (!in_pkt) begin
            if (last_tlast_cyc >= 0) gaps.push_back(cyc - last_tlast_cyc - 1);
            in_pkt = 1;
         end
         if (m_tlast) begin
            port_log.push_back(int'(m_port));
            last_tlast_cyc = cyc;
            in_pkt = 0;
         end
      end else if (in_pkt && !m_tvalid) begin
         intra_gap++;
      end
      prev_stall = m_tvalid && !m_tready;
      snap = {m_tvalid, m_tdata, m_tlast, m_pf, m_vf, m_vf_active, m_port};
      // Upstream acceptances feed the scoreboard from the bench's own cfg table.
      for (int p = 0; p < NP; p++) begin
         if (s_tvalid[p] && s_tready[p]) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            e.tdata = beat_data(p, src_seq[p]);
            e.tlast = s_tlast[p];
            e.pf    = PFW'(cfg_pf_t[p]);
            e.vf    = VFW'(cfg_vf_t[p]);
            e.vfa   = cfg_vfa_t[p][0];
            e.port  = PW'(p);
            sb.push_back(e);
            src_seq[p]++;
            if (src_beat[p] == src_len[p] - 1) begin
               src_beat[p] = 0;
               src_pkts[p]--;
            end else begin
               src_beat[p]++;
            end
         end
      end
   endtask

   function automatic bit idle();
      int pend = 0;
      for (int p = 0; p < NP; p++) pend += src_pkts[p];
      return (pend == 0) && (sb.size() == 0) && !m_tvalid;
   endfunction

   task automatic drain(input string name, input int max, input bit use_pat);
      int k = 0;
      while (!idle() && k < max) begin
         step(use_pat ? rdy_pat[k % 4][0] : 1'b1);
         k++;
      end
      check({name, "_drained"}, 64'(idle()), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      m_tready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_s_tready"}, 64'(s_tready), 64'd0);
      check({name, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
      check({name, "_m_tdata"}, 64'(|m_tdata), 64'd0);
      check({name, "_m_meta"}, 64'({m_tlast, m_pf, m_vf, m_vf_active, m_port}), 64'd0);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got no finish expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[4];
      vecs[0] = '{port: 2, len: 4, exp_pf: 1, exp_vf: 5,    exp_vfa: 1, exp_beats: 4};
      vecs[1] = '{port: 0, len: 1, exp_pf: 3, exp_vf: 17,   exp_vfa: 0, exp_beats: 1};
      vecs[2] = '{port: 3, len: 3, exp_pf: 7, exp_vf: 2047, exp_vfa: 1, exp_beats: 3};
      vecs[3] = '{port: 1, len: 2, exp_pf: 6, exp_vf: 100,  exp_vfa: 1, exp_beats: 2};

      rst = 1'b1;
      m_tready = 1'b1;
      cyc = 0;
      clear_model();
      for (int p = 0; p < NP; p++) begin
         cfg_pf[p*PFW +: PFW] = PFW'(cfg_pf_t[p]);
         cfg_vf[p*VFW +: VFW] = VFW'(cfg_vf_t[p]);
         cfg_vf_active[p]     = cfg_vfa_t[p][0];
      end
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;

      // Single-packet vectors: stamp, beat count and one-cycle latency.
      for (int v = 0; v < 4; v++) begin
         clear_model();
         src_pkts[vecs[v].port] = 1;
         src_len[vecs[v].port]  = vecs[v].len;
         drain("vec", 50, 1'b0);
         check("vec_beats", 64'(out_beats), 64'(vecs[v].exp_beats));
         check("vec_meta", 64'(first_meta),
               64'({PFW'(vecs[v].exp_pf), VFW'(vecs[v].exp_vf), 1'(vecs[v].exp_vfa),
                    PW'(vecs[v].port)}));
         check("vec_latency", 64'(first_out_cyc - first_acc_cyc), 64'd1);
      end

      // Fairness: all ports busy, 2-beat packets.
      do_reset();
      for (int p = 0; p < NP; p++) begin
         src_pkts[p] = 2;
         src_len[p]  = 2;
      end
      drain("fair", 200, 1'b0);
      check("fair_pkts", 64'(port_log.size()), 64'd8);
      for (int i = 0; i < 8; i++) check("fair_order", 64'(port_log[i]), 64'(i % 4));
      check("fair_gap_cnt", 64'(gaps.size()), 64'd7);
      begin
         int bad = 0;
         foreach (gaps[i]) if (gaps[i] != 1) bad++;
         check("fair_bubbles", 64'(bad), 64'd0);
      end
      check("fair_contig", 64'(intra_gap), 64'd0);
      check("fair_one_ready", 64'(multi_rdy), 64'd0);

      // Backpressure: host ready pattern 1,0,0,1 over an 8-beat packet.
      do_reset();
      src_pkts[1] = 1;
      src_len[1]  = 8;
      drain("bp", 200, 1'b1);
      check("bp_beats", 64'(out_beats), 64'd8);
      check("bp_stable", 64'(stab_viol), 64'd0);

      // Atomicity: port 0 stalls mid-packet while port 3 waits.
      do_reset();
      atom_watch       = 1;
      src_pkts[0]      = 1;
      src_len[0]       = 4;
      src_stall_at[0]  = 2;
      src_stall_cnt[0] = 5;
      src_pkts[3]      = 1;
      src_len[3]       = 2;
      drain("atom", 200, 1'b0);
      check("atom_no_ready3", 64'(atom_viol), 64'd0);
      check("atom_pkts", 64'(port_log.size()), 64'd2);
      check("atom_first", 64'(port_log[0]), 64'd0);
      check("atom_second", 64'(port_log[1]), 64'd3);
      check("atom_beats", 64'(out_beats), 64'd6);

      // Reset during beat 3 of a 6-beat packet from port 0.
      do_reset();
      src_pkts[0] = 1;
      src_len[0]  = 6;
      begin
         int k = 0;
         while (src_beat[0] < 3 && k < 50) begin
            step(1'b1);
            k++;
         end
         check("mid_reached", 64'(src_beat[0]), 64'd3);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_rst");
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      src_pkts[0] = 1;
      src_len[0]  = 3;
      drain("post_rst", 50, 1'b0);
      check("post_rst_beats", 64'(out_beats), 64'd3);
      check("post_rst_port", 64'(first_meta[PW-1:0]), 64'd0);

`ifdef PF_VF_TX_ARB_STATS_EN
      do_reset();
      src_pkts[1] = 3;
      src_len[1]  = 2;
      src_pkts[2] = 2;
      src_len[2]  = 1;
      drain("stats", 200, 1'b0);
      check("stat_p0", 64'(stat_pkt_cnt[0 +: 32]), 64'd0);
      check("stat_p1", 64'(stat_pkt_cnt[32 +: 32]), 64'd3);
      check("stat_p2", 64'(stat_pkt_cnt[64 +: 32]), 64'd2);
      check("stat_p3", 64'(stat_pkt_cnt[96 +: 32]), 64'd0);
      check("stat_err", 64'(stat_err), 64'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
